// File: rtl/alb_scoreboard.sv
// alb_scoreboard: clocked checker for ALB results.
//   Reference results are buffered in a DEPTH-entry FIFO. Each valid DUT result
//   is compared against the oldest buffered entry, with per-flag masking.
//   Saturating pass/error counters, first-mismatch capture, halt-on-error and
//   an overflow-corrected value output are provided.
// Ports:
//   clk, reset (async, active-low), start, flush, halt_on_err, cmp_mask{co,vo,no,zo}
//   ref_valid/ref_f/ref_co/ref_vo/ref_no/ref_zo, ref_ready
//   alb_valid/alb_f/alb_co/alb_vo/alb_no/alb_zo
//   pass_cnt, err_cnt, err_pulse, underflow, cap_valid, cap_alb, cap_ref,
//   corr_valid, corrected, state (00 IDLE, 01 RUN, 10 HALT)
// Optional: define ALB_SB_TRACE_EN for a simulation-only trace of every compare.
module alb_scoreboard #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    flush,
  input  logic                    halt_on_err,
  input  logic [3:0]              cmp_mask,
  input  logic                    ref_valid,
  input  logic [DATA_WIDTH-1:0]   ref_f,
  input  logic                    ref_co,
  input  logic                    ref_vo,
  input  logic                    ref_no,
  input  logic                    ref_zo,
  output logic                    ref_ready,
  input  logic                    alb_valid,
  input  logic [DATA_WIDTH-1:0]   alb_f,
  input  logic                    alb_co,
  input  logic                    alb_vo,
  input  logic                    alb_no,
  input  logic                    alb_zo,
  output logic [CNT_WIDTH-1:0]    pass_cnt,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic                    err_pulse,
  output logic                    underflow,
  output logic                    cap_valid,
  output logic [DATA_WIDTH+3:0]   cap_alb,
  output logic [DATA_WIDTH+3:0]   cap_ref,
  output logic                    corr_valid,
  output logic [DATA_WIDTH:0]     corrected,
  output logic [1:0]              state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + 4;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;

  state_t                 state_q, state_d;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [EW-1:0]          mem_d [DEPTH];
  logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CNT_WIDTH-1:0]   pass_cnt_q, pass_cnt_d, err_cnt_q, err_cnt_d;
  logic                   err_pulse_q, err_pulse_d;
  logic                   underflow_q, underflow_d;
  logic                   cap_valid_q, cap_valid_d;
  logic [EW-1:0]          cap_alb_q, cap_alb_d, cap_ref_q, cap_ref_d;
  logic                   corr_valid_q, corr_valid_d;
  logic [DATA_WIDTH:0]    corrected_q, corrected_d;

  logic          run, full, empty, push, do_cmp, mismatch;
  logic [EW-1:0] head, alb_ent, ref_ent;

  assign run     = (state_q == RUN);
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head    = mem_q[rd_q[AW-1:0]];
  assign alb_ent = {alb_f, alb_co, alb_vo, alb_no, alb_zo};
  assign ref_ent = {ref_f, ref_co, ref_vo, ref_no, ref_zo};

  assign push   = run && ref_valid && !full && !flush;
  assign do_cmp = run && alb_valid && !empty && !flush;

  // Case inequality so that X/Z on a compared bit counts as a mismatch in simulation.
  assign mismatch = (alb_f !== head[EW-1:4])
                 || (cmp_mask[3] && (alb_co !== head[3]))
                 || (cmp_mask[2] && (alb_vo !== head[2]))
                 || (cmp_mask[1] && (alb_no !== head[1]))
                 || (cmp_mask[0] && (alb_zo !== head[0]));

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    pass_cnt_d   = pass_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_pulse_d  = 1'b0;
    underflow_d  = underflow_q;
    cap_valid_d  = cap_valid_q;
    cap_alb_d    = cap_alb_q;
    cap_ref_d    = cap_ref_q;
    corr_valid_d = 1'b0;
    corrected_d  = corrected_q;

    if (flush) begin
      state_d     = IDLE;
      wr_d        = '0;
      rd_d        = '0;
      pass_cnt_d  = '0;
      err_cnt_d   = '0;
      underflow_d = 1'b0;
      cap_valid_d = 1'b0;
      cap_alb_d   = '0;
      cap_ref_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (push) begin
            mem_d[wr_q[AW-1:0]] = ref_ent;
            wr_d = wr_q + PW'(1);
          end
          if (do_cmp) begin
            rd_d = rd_q + PW'(1);
            if (mismatch) begin
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
              err_pulse_d = 1'b1;
              if (!cap_valid_q) begin
                cap_valid_d = 1'b1;
                cap_alb_d   = alb_ent;
                cap_ref_d   = head;
              end
              if (halt_on_err) state_d = HALT;
            end else if (pass_cnt_q != '1) begin
              pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
            end
            if (alb_vo) begin
              corr_valid_d = 1'b1;
              corrected_d  = {alb_co, alb_f};
            end
          end else if (alb_valid && empty) begin
            underflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_q        <= '{default: '0};
      wr_q         <= '0;
      rd_q         <= '0;
      pass_cnt_q   <= '0;
      err_cnt_q    <= '0;
      err_pulse_q  <= 1'b0;
      underflow_q  <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_alb_q    <= '0;
      cap_ref_q    <= '0;
      corr_valid_q <= 1'b0;
      corrected_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      pass_cnt_q   <= pass_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_pulse_q  <= err_pulse_d;
      underflow_q  <= underflow_d;
      cap_valid_q  <= cap_valid_d;
      cap_alb_q    <= cap_alb_d;
      cap_ref_q    <= cap_ref_d;
      corr_valid_q <= corr_valid_d;
      corrected_q  <= corrected_d;
    end
  end

  assign ref_ready  = run && !full;
  assign pass_cnt   = pass_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_pulse  = err_pulse_q;
  assign underflow  = underflow_q;
  assign cap_valid  = cap_valid_q;
  assign cap_alb    = cap_alb_q;
  assign cap_ref    = cap_ref_q;
  assign corr_valid = corr_valid_q;
  assign corrected  = corrected_q;
  assign state      = state_q;

`ifdef ALB_SB_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && do_cmp) begin
      $display("ALB: f=%b(%0d) co=%b vo=%b no=%b zo=%b",
               alb_f, $signed(alb_f), alb_co, alb_vo, alb_no, alb_zo);
      if (mismatch) begin
        $display("ERROR @ %0t", $time);
        $display("REF: f=%b(%0d) co=%b vo=%b no=%b zo=%b",
                 head[EW-1:4], $signed(head[EW-1:4]), head[3], head[2], head[1], head[0]);
      end
      if (alb_vo)
        $display("corrected value: f=%b(%0d)", {alb_co, alb_f}, $signed({alb_co, alb_f}));
    end
  end
`else
  // Trace disabled: no simulation-only code is compiled.
`endif

endmodule

// File: tb/tb_alb_scoreboard.sv
module tb_alb_scoreboard;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int EW    = DW + 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, flush = 1'b0, halt_on_err = 1'b0;
  logic [3:0] cmp_mask = 4'b1111;
  logic ref_valid = 1'b0, ref_co = 1'b0, ref_vo = 1'b0, ref_no = 1'b0, ref_zo = 1'b0;
  logic [DW-1:0] ref_f = '0;
  logic alb_valid = 1'b0, alb_co = 1'b0, alb_vo = 1'b0, alb_no = 1'b0, alb_zo = 1'b0;
  logic [DW-1:0] alb_f = '0;
  logic ref_ready, err_pulse, underflow, cap_valid, corr_valid;
  logic [CW-1:0] pass_cnt, err_cnt;
  logic [EW-1:0] cap_alb, cap_ref;
  logic [DW:0] corrected;
  logic [1:0] state;

  always #5 clk = ~clk;

  alb_scoreboard #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .halt_on_err(halt_on_err),
    .cmp_mask(cmp_mask), .ref_valid(ref_valid), .ref_f(ref_f), .ref_co(ref_co),
    .ref_vo(ref_vo), .ref_no(ref_no), .ref_zo(ref_zo), .ref_ready(ref_ready),
    .alb_valid(alb_valid), .alb_f(alb_f), .alb_co(alb_co), .alb_vo(alb_vo),
    .alb_no(alb_no), .alb_zo(alb_zo), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .err_pulse(err_pulse), .underflow(underflow), .cap_valid(cap_valid),
    .cap_alb(cap_alb), .cap_ref(cap_ref), .corr_valid(corr_valid),
    .corrected(corrected), .state(state)
  );

  typedef struct {
    logic rdy; int pass; int err; logic ep; logic uf; logic capv;
    logic [EW-1:0] ca; logic [EW-1:0] cr; logic cv; logic [DW:0] corr; int st;
  } snap_t;

  snap_t expq[$];
  int tests = 0, fails = 0;

  // Reference model: entries as {f,co,vo,no,zo}; state 0 IDLE, 1 RUN, 2 HALT.
  logic [EW-1:0] mq[$];
  int m_pass, m_err, m_st;
  logic m_ep, m_uf, m_capv, m_cv;
  logic [EW-1:0] m_ca, m_cr;
  logic [DW:0] m_corr;

  function automatic void model_reset();
    mq.delete();
    m_pass = 0; m_err = 0; m_st = 0;
    m_ep = 0; m_uf = 0; m_capv = 0; m_cv = 0;
    m_ca = '0; m_cr = '0; m_corr = '0;
  endfunction

  function automatic void model_step(input bit fl, input bit stt, input bit hoe,
                                     input logic [3:0] m, input bit rv, input logic [EW-1:0] re,
                                     input bit av, input logic [EW-1:0] ae);
    logic [EW-1:0] h;
    bit mm, rdy;
    m_ep = 0; m_cv = 0;
    if (fl) begin
      mq.delete();
      m_pass = 0; m_err = 0; m_uf = 0; m_capv = 0; m_ca = '0; m_cr = '0; m_st = 0;
      return;
    end
    if (m_st == 0) begin
      if (stt) m_st = 1;
    end else if (m_st == 1) begin
      rdy = mq.size() < DEPTH;
      if (av && mq.size() > 0) begin
        h = mq.pop_front();
        mm = (ae[EW-1:4] != h[EW-1:4]);
        for (int i = 0; i < 4; i++) if (m[i] && ae[i] != h[i]) mm = 1;
        if (mm) begin
          m_err = (m_err < MAXC) ? m_err + 1 : m_err;
          m_ep = 1;
          if (!m_capv) begin m_capv = 1; m_ca = ae; m_cr = h; end
          if (hoe) m_st = 2;
        end else begin
          m_pass = (m_pass < MAXC) ? m_pass + 1 : m_pass;
        end
        if (ae[2]) begin m_cv = 1; m_corr = {ae[3], ae[EW-1:4]}; end
      end else if (av) begin
        m_uf = 1;
      end
      if (rv && rdy) mq.push_back(re);
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.rdy = (m_st == 1) && (mq.size() < DEPTH);
    s.pass = m_pass; s.err = m_err; s.ep = m_ep; s.uf = m_uf; s.capv = m_capv;
    s.ca = m_ca; s.cr = m_cr; s.cv = m_cv; s.corr = m_corr; s.st = m_st;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [DW-1:0] f, input logic [3:0] fl);
    return {f, fl};
  endfunction

  task automatic set_ref(input logic [EW-1:0] e);
    {ref_f, ref_co, ref_vo, ref_no, ref_zo} = e;
    ref_valid = 1'b1;
  endtask

  task automatic set_alb(input logic [EW-1:0] e);
    {alb_f, alb_co, alb_vo, alb_no, alb_zo} = e;
    alb_valid = 1'b1;
  endtask

  // Applies the current inputs for one edge; the expected post-edge outputs are queued.
  task automatic tick();
    snap_t s;
    model_step(flush, start, halt_on_err, cmp_mask, ref_valid,
               {ref_f, ref_co, ref_vo, ref_no, ref_zo}, alb_valid,
               {alb_f, alb_co, alb_vo, alb_no, alb_zo});
    s = model_snap();
    @(posedge clk);
    expq.push_back(s);
    #1;
    start = 1'b0; flush = 1'b0; ref_valid = 1'b0; alb_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ref_ready"}, ref_ready, 0);
    chk({tag, ".pass_cnt"}, pass_cnt, 0);
    chk({tag, ".err_cnt"}, err_cnt, 0);
    chk({tag, ".err_pulse"}, err_pulse, 0);
    chk({tag, ".underflow"}, underflow, 0);
    chk({tag, ".cap_valid"}, cap_valid, 0);
    chk({tag, ".cap_alb"}, cap_alb, 0);
    chk({tag, ".cap_ref"}, cap_ref, 0);
    chk({tag, ".corr_valid"}, corr_valid, 0);
    chk({tag, ".corrected"}, corrected, 0);
    chk({tag, ".state"}, state, 0);
  endtask

  // Monitor: pops one expected snapshot per observed edge and compares all outputs.
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        s = expq.pop_front();
        chk("ref_ready", ref_ready, s.rdy);
        chk("pass_cnt", pass_cnt, s.pass);
        chk("err_cnt", err_cnt, s.err);
        chk("err_pulse", err_pulse, s.ep);
        chk("underflow", underflow, s.uf);
        chk("cap_valid", cap_valid, s.capv);
        chk("cap_alb", cap_alb, s.ca);
        chk("cap_ref", cap_ref, s.cr);
        chk("corr_valid", corr_valid, s.cv);
        chk("corrected", corrected, s.corr);
        chk("state", state, s.st);
      end
    end
  end

  initial begin
    logic [EW-1:0] e;
    int r, idx;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic match.
    start = 1; tick();
    set_ref(mk(8'h05, 4'b0000)); tick();
    set_alb(mk(8'h05, 4'b0000)); tick();
    tick();

    // Fill to full, then compare with a refused push in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin set_ref(mk(DW'(8'h10 + i), 4'b0000)); tick(); end
    set_alb(mk(8'h10, 4'b0000)); set_ref(mk(8'h99, 4'b0000)); tick();
    for (int i = 1; i < DEPTH; i++) begin set_alb(mk(DW'(8'h10 + i), 4'b0000)); tick(); end

    // Flag masking.
    cmp_mask = 4'b0111;
    set_ref(mk(8'h07, 4'b1000)); tick();
    set_alb(mk(8'h07, 4'b0000)); tick();
    cmp_mask = 4'b1111;
    set_ref(mk(8'h07, 4'b1000)); tick();
    set_alb(mk(8'h07, 4'b0000)); tick();
    tick();

    // Halt on error, start ignored in HALT, flush recovers.
    flush = 1; tick();
    start = 1; tick();
    halt_on_err = 1;
    set_ref(mk(8'h01, 4'b0000)); tick();
    set_ref(mk(8'h02, 4'b0000)); tick();
    set_ref(mk(8'h03, 4'b0000)); tick();
    set_alb(mk(8'h01, 4'b0000)); tick();
    set_alb(mk(8'h22, 4'b0000)); tick();
    set_alb(mk(8'h03, 4'b0000)); set_ref(mk(8'h04, 4'b0000)); tick();
    start = 1; tick();
    flush = 1; start = 1; tick();
    halt_on_err = 0;

    // Overflow correction.
    start = 1; tick();
    set_ref(mk(8'h80, 4'b1100)); tick();
    set_alb(mk(8'h80, 4'b1100)); tick();
    tick();

    // Underflow, alone and with a same-cycle push.
    set_alb(mk(8'h11, 4'b0000)); tick();
    set_alb(mk(8'h12, 4'b0000)); set_ref(mk(8'h12, 4'b0000)); tick();
    set_alb(mk(8'h12, 4'b0000)); tick();

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      set_ref(mk(DW'(i), 4'b0001)); tick();
      set_alb(mk(DW'(i), 4'b0001)); tick();
    end
    for (int i = 0; i < 18; i++) begin
      set_ref(mk(DW'(i), 4'b0000)); tick();
      set_alb(mk(DW'(i + 1), 4'b0000)); tick();
    end
    flush = 1; tick();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      flush = (r < 2);
      start = (m_st == 0) && ($urandom_range(0, 1) == 1);
      halt_on_err = ($urandom_range(0, 99) < 5);
      cmp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 60) set_ref(mk(DW'($urandom), 4'($urandom)));
      if ($urandom_range(0, 99) < 50) begin
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) e = mq[0];
        else e = EW'($urandom);
        if ($urandom_range(0, 9) == 0) begin
          idx = $urandom_range(0, EW - 1);
          e[idx] = ~e[idx];
        end
        set_alb(e);
      end
      tick();
    end

    // Asynchronous reset mid-RUN.
    halt_on_err = 0; cmp_mask = 4'b1111;
    flush = 1; tick();
    start = 1; tick();
    set_ref(mk(8'h33, 4'b0000)); tick();
    set_alb(mk(8'h44, 4'b0000)); set_ref(mk(8'h55, 4'b1111)); tick();
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    start = 1; tick();
    tick();

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d snapshots left, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
